// File: rtl/simple_sync_fifo_pkg.sv
// Shared defaults and sizing helpers for simple_sync_fifo.
package simple_sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 16;

  // Extra MSB on each pointer is the wrap bit that separates full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/simple_sync_fifo_mem.sv
// Storage for simple_sync_fifo: synchronous write port and registered read port.
module simple_sync_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  // Array deliberately has no reset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/simple_sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Optional overflow/underflow pulses enabled by defining SIMPLE_SYNC_FIFO_ERR_EN.
module simple_sync_fifo
  import simple_sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  fifo_full,
`ifdef SIMPLE_SYNC_FIFO_ERR_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  fifo_empty
);

  localparam int PW = ptr_width(FIFO_DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("simple_sync_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("simple_sync_fifo: DATA_WIDTH must be >= 1");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Acceptance looks only at registered flags, so a pop cannot make room
  // for a push in the same cycle, nor a push feed a pop.
  assign push_ok = push && !fifo_full;
  assign pop_ok  = pop && !fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  simple_sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .re    (pop_ok),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

`ifdef SIMPLE_SYNC_FIFO_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= push && fifo_full;
      underflow <= pop && fifo_empty;
    end
  end
`endif

endmodule

// File: tb/tb_simple_sync_fifo.sv
// Directed self-checking bench for simple_sync_fifo (default 32 x 16).
module tb_simple_sync_fifo;

  logic        clk;
  logic        reset;
  logic        push;
  logic [31:0] wr_data;
  logic        pop;
  logic [31:0] rd_data;
  logic        fifo_full;
  logic        fifo_empty;
`ifdef SIMPLE_SYNC_FIFO_ERR_EN
  logic        overflow;
  logic        underflow;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  simple_sync_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .wr_data    (wr_data),
    .pop        (pop),
    .rd_data    (rd_data),
    .fifo_full  (fifo_full),
`ifdef SIMPLE_SYNC_FIFO_ERR_EN
    .overflow   (overflow),
    .underflow  (underflow),
`endif
    .fifo_empty (fifo_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; push = 1'b0; pop = 1'b0; wr_data = '0;
    #10;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (fifo_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", fifo_empty);
    else pass_cnt++;
    total_cnt++;
    if (fifo_full !== 1'b0) $display("FAIL reset_full: got %b want 0", fifo_full);
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== 32'h0) $display("FAIL reset_rd_data: got %h want 00000000", rd_data);
    else pass_cnt++;
`ifdef SIMPLE_SYNC_FIFO_ERR_EN
    total_cnt++;
    if (overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL reset_err_flags: got ovf=%b unf=%b want 0 0", overflow, underflow);
    else pass_cnt++;
`endif
  endtask

  task automatic test_single(input logic [31:0] val);
    tick();
    push = 1'b1; wr_data = val;
    tick();
    push = 1'b0;
    total_cnt++;
    if (fifo_empty !== 1'b0 || fifo_full !== 1'b0)
      $display("FAIL single_flags_%h: got empty=%b full=%b want 0 0", val, fifo_empty, fifo_full);
    else pass_cnt++;
    pop = 1'b1;
    tick();
    total_cnt++;
    if (rd_data !== val) $display("FAIL single_rd_%h: got %h want %h", val, rd_data, val);
    else pass_cnt++;
    tick();
    pop = 1'b0;
    total_cnt++;
    if (fifo_empty !== 1'b1 || rd_data !== val)
      $display("FAIL single_after_%h: got empty=%b rd=%h want 1 %h", val, fifo_empty, rd_data, val);
    else pass_cnt++;
`ifdef SIMPLE_SYNC_FIFO_ERR_EN
    total_cnt++;
    if (underflow !== 1'b1) $display("FAIL underflow_pulse_%h: got %b want 1", val, underflow);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (underflow !== 1'b0) $display("FAIL underflow_clear_%h: got %b want 0", val, underflow);
    else pass_cnt++;
`endif
  endtask

  task automatic test_fill();
    int bad = 0;
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; wr_data = i;
      tick();
      if (i < 15 && fifo_full !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad != 0 || fifo_full !== 1'b1)
      $display("FAIL fill_full: got full=%b early_full=%0d want 1 0", fifo_full, bad);
    else pass_cnt++;
    wr_data = 32'hDEAD;
    tick();
    total_cnt++;
    if (fifo_full !== 1'b1) $display("FAIL push_when_full: got full=%b want 1", fifo_full);
    else pass_cnt++;
`ifdef SIMPLE_SYNC_FIFO_ERR_EN
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL overflow_pulse: got %b want 1", overflow);
    else pass_cnt++;
`endif
    // Push with a concurrent pop while full: pop wins, push still dropped.
    wr_data = 32'hBEEF; pop = 1'b1;
    tick();
    push = 1'b0;
    total_cnt++;
    if (rd_data !== 32'd0 || fifo_full !== 1'b0)
      $display("FAIL full_push_pop: got rd=%h full=%b want 00000000 0", rd_data, fifo_full);
    else pass_cnt++;
`ifdef SIMPLE_SYNC_FIFO_ERR_EN
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL overflow_second: got %b want 1", overflow);
    else pass_cnt++;
`endif
    for (int i = 1; i < 16; i++) begin
      tick();
      total_cnt++;
      if (rd_data !== 32'(i)) $display("FAIL drain_%0d: got %h want %h", i, rd_data, 32'(i));
      else pass_cnt++;
    end
    pop = 1'b0;
    tick();
    total_cnt++;
    if (fifo_empty !== 1'b1 || rd_data !== 32'd15)
      $display("FAIL drain_end: got empty=%b rd=%h want 1 0000000f", fifo_empty, rd_data);
    else pass_cnt++;
`ifdef SIMPLE_SYNC_FIFO_ERR_EN
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL overflow_clear: got %b want 0", overflow);
    else pass_cnt++;
`endif
  endtask

  task automatic test_wrap(input int n, input logic [31:0] base);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      push = 1'b1; wr_data = base + 32'(i);
      tick();
    end
    push = 1'b0; pop = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (rd_data !== base + 32'(i)) bad++;
    end
    pop = 1'b0;
    tick();
    total_cnt++;
    if (bad != 0 || fifo_empty !== 1'b1)
      $display("FAIL wrap_%0d: got bad=%0d empty=%b want 0 1", n, bad, fifo_empty);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [$];
    int bad = 0;
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; wr_data = 32'h200 + 32'(i);
      tick();
    end
    pop = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wr_data = 32'h300 + 32'(k);
      tick();
      if (rd_data !== 32'h200 + 32'(k)) bad++;
    end
    push = 1'b0; pop = 1'b0;
    total_cnt++;
    if (bad != 0 || fifo_empty !== 1'b0 || fifo_full !== 1'b0)
      $display("FAIL b2b_steady: got bad=%0d empty=%b full=%b want 0 0 0", bad, fifo_empty, fifo_full);
    else pass_cnt++;
    exp_q = '{32'h206, 32'h207, 32'h300, 32'h301, 32'h302, 32'h303, 32'h304, 32'h305};
    bad = 0;
    pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rd_data !== exp_q[i]) bad++;
    end
    pop = 1'b0;
    total_cnt++;
    if (bad != 0 || fifo_empty !== 1'b1)
      $display("FAIL b2b_drain: got bad=%0d empty=%b want 0 1", bad, fifo_empty);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; wr_data = 32'h500 + 32'(i);
      tick();
    end
    push = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || rd_data !== 32'h0)
      $display("FAIL async_reset: got empty=%b full=%b rd=%h want 1 0 00000000",
               fifo_empty, fifo_full, rd_data);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    total_cnt++;
    if (rd_data !== 32'h0 || fifo_empty !== 1'b1)
      $display("FAIL pop_after_reset: got rd=%h empty=%b want 00000000 1", rd_data, fifo_empty);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single(32'hAA);
    test_single(32'hBB);
    test_single(32'hCC);
    test_fill();
    test_wrap(10, 32'h1000);
    test_wrap(12, 32'h2000);
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
